// File: rtl/controller_onchip_memory_pkg.sv
// Shared widths, FSM state codes and helpers for the on-chip RAM burst adapter.
package controller_onchip_memory_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BURST_W   = 4;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned MAX_BURST = 2 ** (BURST_W - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RBURST = 2'd1;
    localparam logic [1:0] ST_WBURST = 2'd2;

    // A zero burstcount is serviced as a single beat.
    function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] count);
        return (count == '0) ? BURST_W'(1) : count;
    endfunction

endpackage

// File: rtl/controller_onchip_memory_burst_adapter_if.sv
// Avalon-MM slave (s0) and single-port RAM master (m0) signal bundle.
interface controller_onchip_memory_burst_adapter_if;
    import controller_onchip_memory_pkg::*;

    logic [ADDR_W-1:0]  s0_address;
    logic [BURST_W-1:0] s0_burstcount;
    logic               s0_read;
    logic               s0_write;
    logic [DATA_W-1:0]  s0_writedata;
    logic [BE_W-1:0]    s0_byteenable;
    logic               s0_waitrequest;
    logic [DATA_W-1:0]  s0_readdata;
    logic               s0_readdatavalid;

    logic [ADDR_W-1:0]  m0_address;
    logic [BE_W-1:0]    m0_byteenable;
    logic               m0_chipselect;
    logic               m0_write;
    logic [DATA_W-1:0]  m0_writedata;
    logic               m0_clken;
    logic               m0_reset_req;
    logic [DATA_W-1:0]  m0_readdata;

    // Adapter side.
    modport slave (
        input  s0_address, s0_burstcount, s0_read, s0_write, s0_writedata, s0_byteenable,
        output s0_waitrequest, s0_readdata, s0_readdatavalid,
        output m0_address, m0_byteenable, m0_chipselect, m0_write, m0_writedata,
        output m0_clken, m0_reset_req,
        input  m0_readdata
    );

    // Interconnect plus RAM side.
    modport master (
        output s0_address, s0_burstcount, s0_read, s0_write, s0_writedata, s0_byteenable,
        input  s0_waitrequest, s0_readdata, s0_readdatavalid,
        input  m0_address, m0_byteenable, m0_chipselect, m0_write, m0_writedata,
        input  m0_clken, m0_reset_req,
        output m0_readdata
    );

endinterface

// File: rtl/controller_onchip_memory_burst_adapter.sv
// Splits Avalon-MM bursts into one registered RAM access per cycle and
// tracks the 1-cycle RAM read latency to produce readdatavalid.
module controller_onchip_memory_burst_adapter
    import controller_onchip_memory_pkg::*;
(
    input  logic clk,
    input  logic reset,
    controller_onchip_memory_burst_adapter_if.slave bus
);

    logic [1:0]         state, state_nxt;
    logic [BURST_W-1:0] remaining, remaining_nxt;
    logic [ADDR_W-1:0]  address, address_nxt;
    logic [BE_W-1:0]    byteenable, byteenable_nxt;
    logic [DATA_W-1:0]  writedata, writedata_nxt;
    logic               chipselect, chipselect_nxt;
    logic               write, write_nxt;
    logic               waitrequest;
    logic               readdatavalid;
    logic               clken;
    logic               reset_req;
    logic [BURST_W-1:0] burst_eff;

    assign burst_eff = eff_burst(bus.s0_burstcount);

    // Next-state and next m0 beat; remaining counts beats still to issue.
    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        address_nxt    = address;
        byteenable_nxt = byteenable;
        writedata_nxt  = writedata;
        chipselect_nxt = 1'b0;
        write_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!waitrequest) begin
                    if (bus.s0_write) begin
                        address_nxt    = bus.s0_address;
                        writedata_nxt  = bus.s0_writedata;
                        byteenable_nxt = bus.s0_byteenable;
                        chipselect_nxt = 1'b1;
                        write_nxt      = 1'b1;
                        remaining_nxt  = burst_eff - BURST_W'(1);
                        state_nxt      = (burst_eff > BURST_W'(1)) ? ST_WBURST : ST_IDLE;
                    end else if (bus.s0_read) begin
                        address_nxt    = bus.s0_address;
                        byteenable_nxt = '1;
                        chipselect_nxt = 1'b1;
                        remaining_nxt  = burst_eff - BURST_W'(1);
                        state_nxt      = ST_RBURST;
                    end
                end
            end
            ST_RBURST: begin
                if (remaining != '0) begin
                    address_nxt    = address + ADDR_W'(1);
                    byteenable_nxt = '1;
                    chipselect_nxt = 1'b1;
                    remaining_nxt  = remaining - BURST_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WBURST: begin
                // Gap cycles leave the address parked on the last written word.
                if (bus.s0_write) begin
                    address_nxt    = address + ADDR_W'(1);
                    writedata_nxt  = bus.s0_writedata;
                    byteenable_nxt = bus.s0_byteenable;
                    chipselect_nxt = 1'b1;
                    write_nxt      = 1'b1;
                    remaining_nxt  = remaining - BURST_W'(1);
                    if (remaining == BURST_W'(1)) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            address       <= '0;
            byteenable    <= '0;
            writedata     <= '0;
            chipselect    <= 1'b0;
            write         <= 1'b0;
            waitrequest   <= 1'b1;
            readdatavalid <= 1'b0;
            clken         <= 1'b0;
            reset_req     <= 1'b1;
        end else begin
            state         <= state_nxt;
            remaining     <= remaining_nxt;
            address       <= address_nxt;
            byteenable    <= byteenable_nxt;
            writedata     <= writedata_nxt;
            chipselect    <= chipselect_nxt;
            write         <= write_nxt;
            waitrequest   <= (state_nxt == ST_RBURST);
            readdatavalid <= chipselect & ~write;
            clken         <= 1'b1;
            reset_req     <= 1'b0;
        end
    end

    assign bus.s0_waitrequest   = waitrequest;
    assign bus.s0_readdata      = bus.m0_readdata;
    assign bus.s0_readdatavalid = readdatavalid;
    assign bus.m0_address       = address;
    assign bus.m0_byteenable    = byteenable;
    assign bus.m0_chipselect    = chipselect;
    assign bus.m0_write         = write;
    assign bus.m0_writedata     = writedata;
    assign bus.m0_clken         = clken;
    assign bus.m0_reset_req     = reset_req;

endmodule

// File: tb/tb_controller_onchip_memory_burst_adapter.sv
// Randomized bench for the burst adapter: transaction-level reference of
// expected RAM accesses and read returns, plus a behavioural RAM.
module tb_controller_onchip_memory_burst_adapter;
    import controller_onchip_memory_pkg::*;

    typedef struct { int cyc; logic [DATA_W-1:0] data; } rd_t;
    typedef struct {
        int cyc; logic [ADDR_W-1:0] addr; logic wr; logic [DATA_W-1:0] wd; logic [BE_W-1:0] be;
    } acc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   wait_hi = 0;

    logic [DATA_W-1:0] ram     [2**ADDR_W];
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [DATA_W-1:0] q = '0;

    rd_t  exp_rd[$],  got_rd[$];
    acc_t exp_acc[$], got_acc[$];

    controller_onchip_memory_burst_adapter_if ifc();

    controller_onchip_memory_burst_adapter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ifc.s0_waitrequest) wait_hi <= wait_hi + 1;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r = old_w;
        for (int b = 0; b < int'(BE_W); b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Single-port RAM: registered address, 1-cycle read latency.
    always @(posedge clk) begin
        if (ifc.m0_clken && ifc.m0_chipselect) begin
            if (ifc.m0_write)
                ram[ifc.m0_address] <= merge(ram[ifc.m0_address], ifc.m0_writedata, ifc.m0_byteenable);
            else
                q <= ram[ifc.m0_address];
        end
    end
    assign ifc.m0_readdata = q;

    always @(negedge clk) begin
        if (ifc.s0_readdatavalid) got_rd.push_back('{cyc, ifc.s0_readdata});
        if (ifc.m0_chipselect)
            got_acc.push_back('{cyc, ifc.m0_address, ifc.m0_write,
                                ifc.m0_write ? ifc.m0_writedata : DATA_W'(0),
                                ifc.m0_write ? ifc.m0_byteenable : BE_W'(0)});
    end

    task automatic clear_logs();
        exp_rd.delete(); got_rd.delete(); exp_acc.delete(); got_acc.delete();
    endtask

    task automatic wait_accept(output int t);
        int n = 0;
        while (ifc.s0_waitrequest && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (ifc.s0_waitrequest) begin
            miscompares++;
            $display("FAIL accept_timeout: waitrequest=%0b after %0d cycles, want 0", ifc.s0_waitrequest, n);
            t = -1000;
        end else begin
            t = cyc;
        end
        @(negedge clk);
    endtask

    // gaps[k] inserts an idle cycle (with a stray s0_read) before beat k.
    task automatic do_write(input logic [ADDR_W-1:0] a, input int n_cmd, input logic [MAX_BURST-1:0] gaps,
                            input logic [BE_W-1:0] be_fix, input bit rand_be, input bit with_read);
        int eff = (n_cmd == 0) ? 1 : n_cmd;
        int t;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] ba;
        for (int k = 0; k < eff; k++) begin
            if (k > 0 && gaps[k]) begin
                ifc.s0_write = 1'b0; ifc.s0_read = 1'b1;
                @(negedge clk);
                ifc.s0_read = 1'b0;
            end
            d  = $urandom;
            be = rand_be ? BE_W'($urandom) : be_fix;
            ifc.s0_write      = 1'b1;
            ifc.s0_writedata  = d;
            ifc.s0_byteenable = be;
            ifc.s0_address    = (k == 0) ? a : ADDR_W'($urandom);
            ifc.s0_burstcount = (k == 0) ? BURST_W'(n_cmd) : BURST_W'($urandom);
            ifc.s0_read       = (k == 0) && with_read;
            wait_accept(t);
            ifc.s0_read = 1'b0;
            ba = a + ADDR_W'(k);
            ref_mem[ba] = merge(ref_mem[ba], d, be);
            exp_acc.push_back('{t + 1, ba, 1'b1, d, be});
        end
        ifc.s0_write = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int n_cmd, output int t);
        int eff = (n_cmd == 0) ? 1 : n_cmd;
        logic [ADDR_W-1:0] ba;
        ifc.s0_read       = 1'b1;
        ifc.s0_address    = a;
        ifc.s0_burstcount = BURST_W'(n_cmd);
        wait_accept(t);
        ifc.s0_read = 1'b0;
        for (int k = 0; k < eff; k++) begin
            ba = a + ADDR_W'(k);
            exp_acc.push_back('{t + 1 + k, ba, 1'b0, DATA_W'(0), BE_W'(0)});
            exp_rd.push_back('{t + 2 + k, ref_mem[ba]});
        end
    endtask

    task automatic settle();
        int n = 0;
        while (got_rd.size() < exp_rd.size() && n < 64) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_bus(input string name);
        vectors++;
        if (got_acc.size() != exp_acc.size()) begin
            miscompares++;
            $display("FAIL %s_acc_count: got %0d accesses, want %0d", name, got_acc.size(), exp_acc.size());
        end
        for (int i = 0; i < exp_acc.size() && i < got_acc.size(); i++) begin
            vectors++;
            if (got_acc[i].cyc !== exp_acc[i].cyc || got_acc[i].addr !== exp_acc[i].addr ||
                got_acc[i].wr !== exp_acc[i].wr || got_acc[i].wd !== exp_acc[i].wd ||
                got_acc[i].be !== exp_acc[i].be) begin
                miscompares++;
                $display("FAIL %s_acc[%0d]: got cyc=%0d a=%h w=%0b d=%h be=%h, want cyc=%0d a=%h w=%0b d=%h be=%h",
                         name, i, got_acc[i].cyc, got_acc[i].addr, got_acc[i].wr, got_acc[i].wd, got_acc[i].be,
                         exp_acc[i].cyc, exp_acc[i].addr, exp_acc[i].wr, exp_acc[i].wd, exp_acc[i].be);
            end
        end
    endtask

    task automatic check_reads(input string name);
        vectors++;
        if (got_rd.size() != exp_rd.size()) begin
            miscompares++;
            $display("FAIL %s_valid_count: got %0d valids, want %0d", name, got_rd.size(), exp_rd.size());
        end
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
            vectors++;
            if (got_rd[i].cyc !== exp_rd[i].cyc || got_rd[i].data !== exp_rd[i].data) begin
                miscompares++;
                $display("FAIL %s_rd[%0d]: got cyc=%0d d=%h, want cyc=%0d d=%h",
                         name, i, got_rd[i].cyc, got_rd[i].data, exp_rd[i].cyc, exp_rd[i].data);
            end
        end
    endtask

    task automatic prune_from(input int r);
        for (int i = exp_acc.size() - 1; i >= 0; i--) if (exp_acc[i].cyc >= r) exp_acc.delete(i);
        for (int i = exp_rd.size() - 1; i >= 0; i--)  if (exp_rd[i].cyc >= r)  exp_rd.delete(i);
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        repeat (2) @(negedge clk);
        obs = {ifc.s0_waitrequest, ifc.m0_reset_req, ifc.m0_clken, ifc.m0_chipselect,
               ifc.m0_write, ifc.s0_readdatavalid, |ifc.m0_address};
        vectors++;
        if (obs !== 7'b1100000) begin
            miscompares++;
            $display("FAIL reset_state: got %b, want 1100000", obs);
        end
        reset = 1'b0;
        vectors++;
        if ({ifc.m0_reset_req, ifc.m0_clken, ifc.s0_waitrequest} !== 3'b101) begin
            miscompares++;
            $display("FAIL reset_release_pre: got %b, want 101",
                     {ifc.m0_reset_req, ifc.m0_clken, ifc.s0_waitrequest});
        end
        @(negedge clk);
        vectors++;
        if ({ifc.m0_reset_req, ifc.m0_clken, ifc.s0_waitrequest} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_release_post: got %b, want 010",
                     {ifc.m0_reset_req, ifc.m0_clken, ifc.s0_waitrequest});
        end
        clear_logs();
        repeat (4) @(negedge clk);
        check_bus("reset_idle");
        check_reads("reset_idle");
    endtask

    task automatic test_write_readback();
        int t, w0;
        clear_logs();
        w0 = wait_hi;
        do_write(12'h010, 4, '0, 4'hF, 1'b0, 1'b0);
        vectors++;
        if (wait_hi !== w0) begin
            miscompares++;
            $display("FAIL wr_waitrequest: got %0d high cycles, want 0", wait_hi - w0);
        end
        do_read(12'h010, 4, t);
        settle();
        check_bus("wr_rb");
        check_reads("wr_rb");
    endtask

    task automatic test_wrap();
        int t;
        clear_logs();
        do_write(12'hFFE, 4, '0, 4'hF, 1'b0, 1'b0);
        do_read(12'hFFE, 4, t);
        settle();
        check_bus("wrap");
        check_reads("wrap");
    endtask

    task automatic test_gap_byteenable();
        int t;
        clear_logs();
        do_write(12'h020, 3, '0, 4'hF, 1'b0, 1'b0);
        do_write(12'h020, 3, 8'b0000_0100, 4'b0010, 1'b0, 1'b0);
        do_read(12'h020, 3, t);
        settle();
        check_bus("gap_be");
        check_reads("gap_be");
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        clear_logs();
        do_write(12'h040, 3, '0, 4'hF, 1'b0, 1'b0);
        do_read(12'h040, 2, t1);
        do_read(12'h042, 1, t2);
        vectors++;
        if (t2 !== t1 + 3) begin
            miscompares++;
            $display("FAIL b2b_accept: got cycle %0d, want %0d", t2, t1 + 3);
        end
        settle();
        check_bus("b2b");
        check_reads("b2b");
    endtask

    task automatic test_reset_mid_burst();
        int t, r;
        clear_logs();
        do_read(12'h100, 8, t);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        r = cyc;
        prune_from(r);
        @(negedge clk);
        vectors++;
        if ({ifc.s0_waitrequest, ifc.m0_reset_req, ifc.m0_chipselect, ifc.s0_readdatavalid} !== 4'b1100) begin
            miscompares++;
            $display("FAIL midreset_state: got %b, want 1100",
                     {ifc.s0_waitrequest, ifc.m0_reset_req, ifc.m0_chipselect, ifc.s0_readdatavalid});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (ifc.s0_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_idle: got waitrequest=%b, want 0", ifc.s0_waitrequest);
        end
        settle();
        check_bus("midreset");
        check_reads("midreset");
        clear_logs();
        do_read(12'h123, 0, t);
        settle();
        check_bus("burst0");
        check_reads("burst0");
    endtask

    task automatic test_random();
        int t;
        logic [ADDR_W-1:0] a;
        int n;
        for (int it = 0; it < 8; it++) begin
            clear_logs();
            a = ADDR_W'($urandom);
            n = $urandom_range(MAX_BURST, 0);
            do_write(a, n, MAX_BURST'($urandom), 4'h0, 1'b1, 1'($urandom));
            do_read(a, n, t);
            do_read(ADDR_W'($urandom), $urandom_range(MAX_BURST, 0), t);
            settle();
            check_bus("rand");
            check_reads("rand");
        end
    endtask

    initial begin
        ifc.s0_address = '0; ifc.s0_burstcount = '0; ifc.s0_read = 1'b0;
        ifc.s0_write = 1'b0; ifc.s0_writedata = '0; ifc.s0_byteenable = '0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            ref_mem[i] = $urandom;
            ram[i] <= ref_mem[i];
        end
        test_reset();
        test_write_readback();
        test_wrap();
        test_gap_byteenable();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
